// File: rtl/sio_frame_rx.sv
// Serial frame receiver: waits for a qualified idle run, takes a '1' start bit,
// shifts in DATA_BITS data bits MSB first, then checks the word and keeps ATE counters.
module sio_frame_rx #(
  parameter int DATA_BITS = 10,
  parameter int MIN_IDLE  = 16
) (
  input  logic                 SioClk,
  input  logic                 SioRst,
  input  logic                 SioDat,
  input  logic [DATA_BITS-1:0] ExpWord,
  input  logic                 CheckEn,
  output logic [DATA_BITS-1:0] RxWord,
  output logic                 RxValid,
  output logic                 RxMatch,
  output logic                 FrameErr,
  output logic [15:0]          FrameCount,
  output logic [15:0]          ErrCount,
  output logic                 Locked
);

  localparam int IW = $clog2(MIN_IDLE + 1);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [IW-1:0] IDLE_MAX = IW'(MIN_IDLE);
  localparam logic [BW-1:0] NBITS    = BW'(DATA_BITS);

  typedef enum logic [1:0] {IDLE, ARMED, DATA} state_t;

  state_t               state, state_nxt;
  logic [IW-1:0]        idle_cnt, idle_inc;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [15:0]          frame_cnt, err_cnt;

  logic frame_done, frame_err, word_match, mismatch;

  assign idle_inc  = (idle_cnt == IDLE_MAX) ? idle_cnt : idle_cnt + 1'b1;
  assign shift_nxt = {shift[DATA_BITS-2:0], SioDat};

  always_ff @(posedge SioClk) begin
    if (SioRst) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!SioDat && idle_inc == IDLE_MAX) state_nxt = ARMED;
      ARMED:   if (SioDat) state_nxt = DATA;
      DATA:    if (bit_cnt == BW'(1)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes for the current edge; the datapath registers act on them.
  always_comb begin
    frame_done = (state == DATA) && (bit_cnt == BW'(1));
    frame_err  = (state == IDLE) && SioDat && (idle_cnt < IDLE_MAX);
    word_match = (shift_nxt == ExpWord);
    mismatch   = frame_done && CheckEn && !word_match;
  end

  always_ff @(posedge SioClk) begin
    if (SioRst) begin
      idle_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      RxWord    <= '0;
      RxValid   <= 1'b0;
      RxMatch   <= 1'b0;
      FrameErr  <= 1'b0;
      frame_cnt <= '0;
      err_cnt   <= '0;
      Locked    <= 1'b0;
    end else begin
      RxValid  <= frame_done;
      FrameErr <= frame_err;
      case (state)
        IDLE: begin
          if (!SioDat)       idle_cnt <= idle_inc;
          else if (frame_err) idle_cnt <= '0;
        end
        ARMED: if (SioDat) bit_cnt <= NBITS;
        DATA: begin
          shift   <= shift_nxt;
          bit_cnt <= bit_cnt - 1'b1;
          if (frame_done) idle_cnt <= '0;
        end
        default: ;
      endcase
      if (frame_done) begin
        RxWord  <= shift_nxt;
        RxMatch <= word_match;
        if (frame_cnt != 16'hFFFF) frame_cnt <= frame_cnt + 1'b1;
      end
      // Error sources live in different states, so at most one increment per edge.
      if ((frame_err || mismatch) && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
      if (frame_done && word_match)   Locked <= 1'b1;
      else if (frame_err || mismatch) Locked <= 1'b0;
    end
  end

  assign FrameCount = frame_cnt;
  assign ErrCount   = err_cnt;

endmodule

// File: tb/tb_sio_frame_rx.sv
// Scoreboard bench for sio_frame_rx: directed frames push expected strobes,
// a negedge monitor pops and compares them, then checks counters a cycle later.
module tb_sio_frame_rx;

  logic       SioClk = 1'b0;
  logic       SioRst, SioDat, CheckEn;
  logic [9:0] ExpWord, RxWord;
  logic       RxValid, RxMatch, FrameErr, Locked;
  logic [15:0] FrameCount, ErrCount;

  sio_frame_rx #(.DATA_BITS(10), .MIN_IDLE(16)) dut (
    .SioClk(SioClk), .SioRst(SioRst), .SioDat(SioDat), .ExpWord(ExpWord),
    .CheckEn(CheckEn), .RxWord(RxWord), .RxValid(RxValid), .RxMatch(RxMatch),
    .FrameErr(FrameErr), .FrameCount(FrameCount), .ErrCount(ErrCount), .Locked(Locked)
  );

  always #5 SioClk = ~SioClk;

  int cyc = 0;
  always @(posedge SioClk) cyc++;

  typedef struct {
    bit         fe;
    logic [9:0] word;
    bit         match;
    logic [15:0] fc, ec;
    bit         lk;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_fail = 0;
  logic [15:0] m_fc = 0, m_ec = 0;
  bit m_lk = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [15:0] sat(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin @(negedge SioClk); SioDat = 1'b0; end
  endtask

  // bits: what goes on the line; want: hand-derived expected RxWord.
  task automatic frame(input logic [9:0] bits, input logic [9:0] want);
    exp_t e;
    @(negedge SioClk);
    SioDat = 1'b1;
    e.fe = 0; e.word = want; e.match = (want == ExpWord);
    e.cyc = cyc + 1 + 10;
    m_fc = sat(m_fc);
    if (CheckEn && !e.match) m_ec = sat(m_ec);
    if (e.match) m_lk = 1;
    else if (CheckEn) m_lk = 0;
    e.fc = m_fc; e.ec = m_ec; e.lk = m_lk;
    q.push_back(e);
    for (int i = 9; i >= 0; i--) begin @(negedge SioClk); SioDat = bits[i]; end
  endtask

  task automatic ferr();
    exp_t e;
    @(negedge SioClk);
    SioDat = 1'b1;
    m_ec = sat(m_ec); m_lk = 0;
    e.fe = 1; e.word = 0; e.match = 0; e.cyc = cyc + 1;
    e.fc = m_fc; e.ec = m_ec; e.lk = m_lk;
    q.push_back(e);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_word"},  32'(RxWord), 0);
    chk({tag, "_vld"},   32'(RxValid), 0);
    chk({tag, "_match"}, 32'(RxMatch), 0);
    chk({tag, "_ferr"},  32'(FrameErr), 0);
    chk({tag, "_fc"},    32'(FrameCount), 0);
    chk({tag, "_ec"},    32'(ErrCount), 0);
    chk({tag, "_lock"},  32'(Locked), 0);
  endtask

  task automatic do_reset();
    @(negedge SioClk); SioRst = 1'b1; SioDat = 1'b0;
    @(negedge SioClk); SioRst = 1'b0;
    m_fc = 0; m_ec = 0; m_lk = 0;
  endtask

  // Monitor
  exp_t pe;
  bit   pend = 0;
  always @(negedge SioClk) begin
    if (pend) begin
      chk("frame_count", 32'(FrameCount), 32'(pe.fc));
      chk("err_count",   32'(ErrCount),   32'(pe.ec));
      chk("locked",      32'(Locked),     32'(pe.lk));
      pend = 0;
    end
    if (RxValid || FrameErr) begin
      if (q.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_strobe: got RxValid=%0b FrameErr=%0b want none (cycle %0d)", RxValid, FrameErr, cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("strobe_kind", {30'd0, RxValid, FrameErr}, e.fe ? 32'd1 : 32'd2);
        chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
        if (!e.fe) begin
          chk("rx_word",  32'(RxWord),  32'(e.word));
          chk("rx_match", 32'(RxMatch), 32'(e.match));
        end
        pe = e; pend = 1;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    SioRst = 1'b1; SioDat = 1'b0; ExpWord = '0; CheckEn = 1'b1;
    repeat (2) @(negedge SioClk);
    do_reset();
    check_zero("reset");

    // Basic matching frame
    ExpWord = 10'h2A5;
    idle(22); frame(10'b1010100101, 10'h2A5); idle(16);

    // Match then mismatch, then a short idle run before a stray '1'
    ExpWord = 10'h3FF;
    idle(22); frame(10'b1111111111, 10'h3FF); idle(16);
    frame(10'b0000000000, 10'h000);
    idle(10); ferr();
    ExpWord = 10'h2A5;
    idle(16); frame(10'b1010100101, 10'h2A5); idle(16);

    // Reset after 4 data bits abandons the frame
    @(negedge SioClk); SioDat = 1'b1;
    for (int i = 0; i < 4; i++) begin @(negedge SioClk); SioDat = i[0]; end
    do_reset();
    check_zero("midrst");
    idle(5); ferr();
    ExpWord = 10'h1C3;
    idle(16); frame(10'b0111000011, 10'h1C3); idle(16);

    // Mismatch with checking disabled
    CheckEn = 1'b0; ExpWord = 10'h2AA;
    frame(10'b0101010101, 10'h155); idle(16);

    // Saturation of both counters
    CheckEn = 1'b1;
    @(negedge SioClk);
    force dut.frame_cnt = 16'hFFFE;
    force dut.err_cnt   = 16'hFFFE;
    @(negedge SioClk);
    release dut.frame_cnt;
    release dut.err_cnt;
    m_fc = 16'hFFFE; m_ec = 16'hFFFE;
    idle(2);
    chk("preload_fc", 32'(FrameCount), 32'hFFFE);
    chk("preload_ec", 32'(ErrCount),   32'hFFFE);
    idle(16);
    repeat (3) begin frame(10'b0101010101, 10'h155); idle(16); end
    frame(10'b0101010101, 10'h155);
    idle(3); ferr(); ferr(); ferr();
    idle(20);

    chk("queue_empty", 32'(q.size()), 0);
    chk("no_pending", 32'(pend), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
